// File: rtl/uart_pkg.sv
// uart_pkg: UART frame constants and the receiver state encoding, shared by the receiver and transmitter.
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int OVS = 16;
  localparam int START_SAMPLE = 7;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider that emits a one-clock s_tick every DVSR clocks (16x oversample).
module uart_baud_gen #(
  parameter int DVSR = 423
) (
  input  logic clk,
  input  logic rst_n,
  output logic s_tick
);
  localparam int W = DVSR > 1 ? $clog2(DVSR) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= s_tick ? '0 : cnt + W'(1);
  assign s_tick = cnt == W'(DVSR - 1);
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling feeding a small show-ahead FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 65_000_000,
  parameter int BAUD = 9600,
  parameter int DVSR = CLK_HZ / (16 * BAUD),
  parameter int ADDR_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd_uart,
  output logic [7:0] get_uart,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       rx_busy
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  logic rx_m, rx_s, s_tick, push, wr, rd;
  rx_state_t state;
  logic [3:0] s_cnt;
  logic [2:0] n_cnt;
  logic [7:0] b_reg;
  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [ADDR_W:0] count;

  uart_baud_gen #(.DVSR(DVSR)) u_baud (
    .clk(clk),
    .rst_n(rst_n),
    .s_tick(s_tick)
  );

  // Synchronizer loads idle-high in reset so release never looks like a start bit.
  always_ff @(posedge clk)
    if (!rst_n) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {rx, rx_m};

  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      s_cnt <= '0;
      n_cnt <= '0;
      b_reg <= '0;
      push <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      push <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          s_cnt <= '0;
        end
        START: if (s_tick) begin
          if (s_cnt == 4'(START_SAMPLE)) begin
            state <= rx_s ? IDLE : DATA;
            s_cnt <= '0;
            n_cnt <= '0;
          end else s_cnt <= s_cnt + 4'd1;
        end
        DATA: if (s_tick) begin
          if (s_cnt == 4'(OVS - 1)) begin
            s_cnt <= '0;
            b_reg <= {rx_s, b_reg[DATA_BITS-1:1]};
            n_cnt <= n_cnt + 3'd1;
            if (n_cnt == 3'(DATA_BITS - 1)) state <= STOP;
          end else s_cnt <= s_cnt + 4'd1;
        end
        STOP: if (s_tick) begin
          if (s_cnt == 4'(OVS - 1)) begin
            state <= IDLE;
            push <= rx_s;
            framing_err <= !rx_s;
          end else s_cnt <= s_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end

  assign rx_busy = state != IDLE;
  assign rx_empty = count == '0;
  assign rx_full = count == DEPTH;
  assign rd = rd_uart && !rx_empty;
  assign wr = push && (!rx_full || rd);
  assign rd_nxt = rd_ptr + ADDR_W'(1);

  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= b_reg;

  // get_uart is a registered copy of the head; it only moves when the head changes.
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      get_uart <= '0;
      overrun_err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(wr);
      rd_ptr <= rd_ptr + ADDR_W'(rd);
      count <= count + (ADDR_W+1)'(wr) - (ADDR_W+1)'(rd);
      overrun_err <= push && !wr;
      if (wr && (rx_empty || (rd && count == (ADDR_W+1)'(1)))) get_uart <= b_reg;
      else if (rd && count != (ADDR_W+1)'(1)) get_uart <= mem[rd_nxt];
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random 8N1 frames checked against a queue model of the receive FIFO.
module tb_uart_rx_fifo;
  localparam int DVSR = 4;
  localparam int BIT = 16 * DVSR;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic rd_uart = 1'b0;
  logic [7:0] get_uart;
  logic rx_empty, rx_full, framing_err, overrun_err, rx_busy;
  int total = 0, passed = 0;
  int ferr_cnt = 0, ovr_cnt = 0, exp_ferr = 0, exp_ovr = 0;
  logic [7:0] q[$];
  logic [7:0] head = 8'h00;

  uart_rx_fifo #(.DVSR(DVSR)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .rd_uart(rd_uart),
    .get_uart(get_uart),
    .rx_empty(rx_empty),
    .rx_full(rx_full),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // Counting high cycles makes a stretched pulse show up as an extra error.
  always @(negedge clk)
    if (rst_n) begin
      if (framing_err) ferr_cnt++;
      if (overrun_err) ovr_cnt++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":empty"}, rx_empty, q.size() == 0);
    chk({tag, ":full"}, rx_full, q.size() == 4);
    chk({tag, ":head"}, get_uart, head);
    chk({tag, ":ferr"}, ferr_cnt, exp_ferr);
    chk({tag, ":ovr"}, ovr_cnt, exp_ovr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    rd_uart = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    head = 8'h00;
  endtask

  task automatic pop();
    rd_uart = 1'b1;
    @(posedge clk);
    #1;
    rd_uart = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    if (q.size() != 0) head = q[0];
    check_state("pop");
  endtask

  // Stop bit is released high for its last quarter so a bad stop bit never chains into a new frame.
  task automatic send(input logic [7:0] d, input logic stop, input bit pop_at_push, input int abort);
    logic [9:0] f;
    bit seen, popped;
    f = {stop, d, 1'b0};
    seen = 0;
    popped = 0;
    for (int i = 0; i < 10 * BIT; i++) begin
      if (i == abort * BIT) begin
        do_reset();
        return;
      end
      rx = (i >= 9 * BIT + 3 * BIT / 4) ? 1'b1 : f[i / BIT];
      @(posedge clk);
      #1;
      rd_uart = 1'b0;
      if (rx_busy) seen = 1;
      if (pop_at_push && seen && !rx_busy && !popped) begin
        rd_uart = 1'b1;
        popped = 1;
      end
    end
    rd_uart = 1'b0;
    rx = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #1;
    if (pop_at_push) chk("pop_sync", popped, 1);
    chk("busy_seen", seen, 1);
    if (!stop) exp_ferr++;
    else begin
      if (pop_at_push && q.size() != 0) void'(q.pop_front());
      if (q.size() == 4) exp_ovr++;
      else q.push_back(d);
    end
    if (q.size() != 0) head = q[0];
    check_state("frame");
  endtask

  initial begin
    logic [7:0] d;
    logic s;
    do_reset();
    chk("rst:get_uart", get_uart, 8'h00);
    chk("rst:empty", rx_empty, 1);
    chk("rst:full", rx_full, 0);
    chk("rst:ferr", framing_err, 0);
    chk("rst:ovr", overrun_err, 0);
    chk("rst:busy", rx_busy, 0);
    send(8'hFF, 1'b1, 0, -1);
    pop();
    send(8'hA5, 1'b1, 0, -1);
    send(8'h3C, 1'b1, 0, -1);
    send(8'h01, 1'b1, 0, -1);
    repeat (3) pop();
    pop();
    send(8'h55, 1'b0, 0, -1);
    for (int i = 0; i < 5; i++) send(8'(i), 1'b1, 0, -1);
    repeat (4) pop();
    for (int i = 0; i < 4; i++) send(8'(i), 1'b1, 0, -1);
    send(8'h04, 1'b1, 1, -1);
    repeat (4) pop();
    rx = 1'b0;
    repeat (4 * DVSR) @(posedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    #1;
    chk("glitch:busy", rx_busy, 0);
    check_state("glitch");
    send(8'hC3, 1'b1, 0, 4);
    chk("abort:busy", rx_busy, 0);
    repeat (BIT) @(posedge clk);
    #1;
    check_state("abort");
    send(8'h7E, 1'b1, 0, -1);
    pop();
    repeat (8) begin
      d = 8'($urandom);
      s = $urandom_range(0, 4) != 0;
      send(d, s, 0, -1);
      repeat ($urandom_range(0, 2)) pop();
    end
    repeat (5) pop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
